// File: rtl/fifo_arb_pkg.sv
// Shared constants for the io881 fifo write arbiters: index/count widths and stat counter limits.
package fifo_arb_pkg;

  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_SAT = 16'hFFFF;

  // Smallest index width that can address n channels.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a burst counter that must hold values 0..b.
  function automatic int unsigned cnt_width(input int unsigned b);
    return (b < 2) ? 1 : $clog2(b + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request at or after i_start, wrapping at N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [31:0] w_dist;
  logic [31:0] w_best;

  // Rank every set request by its rotated distance from i_start; smallest distance wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_dist  = '0;
    w_best  = N;
    for (int unsigned i = 0; i < N; i++) begin
      w_dist = (i + N - 32'(i_start)) % N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_idx   = IW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharer of one fifo write port with per-owner burst lock.
// Optional per-channel write statistics under `define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 2,
  parameter int unsigned IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      fifo_d_in,
  output logic                  fifo_d_in_strobe,
  input  logic                  fifo_full,
  output logic [IDXW-1:0]       owner,
  output logic                  locked
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [IDXW-1:0]       stat_sel,
  input  logic                  stat_clear,
  output logic [STAT_W-1:0]     stat_count
`endif
);

  localparam int unsigned CntW = cnt_width(BURST);
  localparam logic [IDXW-1:0] LastIdx = IDXW'(NREQ - 1);

  logic [IDXW-1:0] r_owner;
  logic [CntW-1:0] r_cnt;
  logic            r_locked;

  logic [IDXW-1:0] w_start;
  logic            w_owner_req;
  logic            w_rr_found;
  logic [IDXW-1:0] w_rr_idx;
  logic            w_hold;
  logic            w_found;
  logic [IDXW-1:0] w_cand;
  logic            w_fire;
  logic [CntW-1:0] w_new_cnt;

  // Search begins just past the last owner so the owner itself is checked last.
  assign w_start = (r_owner == LastIdx) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_owner_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_owner == IDXW'(i)) w_owner_req = req[i];
    end
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IDXW)
  ) u_rr_pick (
    .i_req   (req),
    .i_start (w_start),
    .o_found (w_rr_found),
    .o_idx   (w_rr_idx)
  );

  assign w_hold  = r_locked && w_owner_req;
  assign w_found = w_hold || w_rr_found;
  assign w_cand  = w_hold ? r_owner : w_rr_idx;
  assign w_fire  = w_found && !fifo_full && !reset;

  always_comb begin
    fifo_d_in = '0;
    ack       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_found && (w_cand == IDXW'(i))) begin
        fifo_d_in = req_data[i*WIDTH +: WIDTH];
        ack[i]    = w_fire;
      end
    end
  end

  assign fifo_d_in_strobe = w_fire;

  assign w_new_cnt = (r_locked && (w_cand == r_owner)) ? r_cnt + 1'b1 : CntW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner  <= LastIdx;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (w_fire) begin
      r_owner  <= w_cand;
      r_cnt    <= w_new_cnt;
      r_locked <= (32'(w_new_cnt) < BURST);
    end else if (r_locked && !w_owner_req) begin
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end
  end

  assign owner  = r_owner;
  assign locked = r_locked;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat [NREQ];
  logic [STAT_W-1:0] r_stat_count;
  logic [STAT_W-1:0] w_stat_rd;

  always_comb begin
    w_stat_rd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (stat_sel == IDXW'(i)) w_stat_rd = r_stat[i];
    end
  end

  // A fire coincident with stat_clear is dropped, not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_count <= '0;
      for (int unsigned i = 0; i < NREQ; i++) r_stat[i] <= '0;
    end else begin
      r_stat_count <= w_stat_rd;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (stat_clear) begin
          r_stat[i] <= '0;
        end else if (w_fire && (w_cand == IDXW'(i)) && (r_stat[i] != STAT_SAT)) begin
          r_stat[i] <= r_stat[i] + 1'b1;
        end
      end
    end
  end

  assign stat_count = r_stat_count;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed checks of fifo_wr_arbiter against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    ack;
  logic [W-1:0]    fifo_d_in;
  logic            fifo_d_in_strobe;
  logic            fifo_full;
  logic [IW-1:0]   owner;
  logic            locked;
  logic [IW-1:0]   stat_sel;
  logic            stat_clear;
  logic [15:0]     stat_count;

  logic [W-1:0]    dat [N];

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  int          m_owner;
  int          m_cnt;
  bit          m_locked;
  int          m_stat [N];
  int          m_stat_q;

  logic [W-1:0] fq[$];
  int          fdepth;
  int          drain_mode;

  bit          l_fire;
  int          l_cand;
  logic [N-1:0] l_obs_ack;
  logic [W-1:0] l_obs_d;
  logic        l_obs_stb;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
  end

  fifo_wr_arbiter #(
    .WIDTH (W),
    .NREQ  (N),
    .BURST (B),
    .IDXW  (IW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_data         (req_data),
    .ack              (ack),
    .fifo_d_in        (fifo_d_in),
    .fifo_d_in_strobe (fifo_d_in_strobe),
    .fifo_full        (fifo_full),
    .owner            (owner),
    .locked           (locked)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_sel         (stat_sel),
    .stat_clear       (stat_clear),
    .stat_count       (stat_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner by the arbitration rules: locked owner keeps the port, else first requester after owner.
  function automatic int pick();
    if (m_locked && req[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (req[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle();
    int           cand;
    bit           fire;
    int           nc;
    logic [N-1:0] ea;
    logic [W-1:0] ed;
    fifo_full = (fq.size() >= fdepth);
    #1;
    cand = pick();
    fire = (cand >= 0) && !fifo_full && !reset;
    ea = '0;
    if (fire) ea[cand] = 1'b1;
    ed = (cand >= 0) ? dat[cand] : '0;
    check_eq("ack", ack, ea);
    check_eq("strobe", fifo_d_in_strobe, fire);
    check_eq("d_in", fifo_d_in, ed);
    l_fire = fire;
    l_cand = cand;
    l_obs_ack = ack;
    l_obs_d = fifo_d_in;
    l_obs_stb = fifo_d_in_strobe;
    @(posedge clk);
    if (fq.size() > 0) begin
      if (drain_mode == 1 || (drain_mode == 2 && $urandom_range(0, 1) == 1)) begin
        void'(fq.pop_front());
      end else if (drain_mode == 3) begin
        void'(fq.pop_front());
        drain_mode = 0;
      end
    end
    if (fire) fq.push_back(ed);
    if (reset) begin
      m_stat_q = 0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
    end else begin
      m_stat_q = (int'(stat_sel) < N) ? m_stat[stat_sel] : 0;
      if (stat_clear) begin
        for (int i = 0; i < N; i++) m_stat[i] = 0;
      end else if (fire && m_stat[cand] < 65535) begin
        m_stat[cand]++;
      end
    end
    if (reset) begin
      m_owner = N - 1;
      m_cnt = 0;
      m_locked = 0;
    end else if (fire) begin
      nc = (m_locked && cand == m_owner) ? m_cnt + 1 : 1;
      m_owner = cand;
      m_cnt = nc;
      m_locked = (nc < B);
    end else if (m_locked && !req[m_owner]) begin
      m_locked = 0;
      m_cnt = 0;
    end
    #1;
    check_eq("owner", owner, m_owner);
    check_eq("locked", locked, m_locked);
`ifdef FIFO_ARB_STATS_EN
    check_eq("stat_count", stat_count, m_stat_q);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    fq.delete();
  endtask

  logic [W-1:0] order [9];

  initial begin
    reset = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    stat_sel = '0;
    stat_clear = 1'b0;
    fdepth = 4;
    drain_mode = 1;
    m_owner = 0;
    m_cnt = 0;
    m_locked = 0;
    m_stat_q = 0;
    for (int i = 0; i < N; i++) m_stat[i] = 0;

    // Reset state and first grant.
    do_reset();
    check_eq("rst_owner", owner, 3);
    check_eq("rst_locked", locked, 0);
    req = 4'b0001;
    dat[0] = 8'h55;
    cycle();
    check_eq("t1_ack", l_obs_ack, 4'b0001);
    check_eq("t1_stb", l_obs_stb, 1);
    check_eq("t1_din", l_obs_d, 8'h55);
    check_eq("t1_owner", owner, 0);
    check_eq("t1_locked", locked, 1);

    // All requesting: BURST writes per channel, then rotate.
    do_reset();
    order = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13, 8'h10};
    for (int i = 0; i < N; i++) dat[i] = 8'h10 + 8'(i);
    req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      cycle();
      check_eq("t2_order", l_obs_d, order[k]);
      check_eq("t2_lock", locked, (k % 2 == 0) ? 1 : 0);
    end

    // Small fifo left undrained: stalls while full, then next channel.
    req = '0;
    do_reset();
    fdepth = 2;
    drain_mode = 0;
    dat[0] = 8'hA0;
    dat[1] = 8'hA1;
    req = 4'b0011;
    cycle();
    cycle();
    check_eq("t3_second", l_obs_d, 8'hA0);
    cycle();
    check_eq("t3_full_stb", l_obs_stb, 0);
    check_eq("t3_full_ack", l_obs_ack, 0);
    drain_mode = 3;
    cycle();
    cycle();
    check_eq("t3_resume_ack", l_obs_ack, 4'b0010);
    check_eq("t3_resume_d", l_obs_d, 8'hA1);

    // Locked owner drops req: next channel wins and takes a new lock.
    req = '0;
    fdepth = 4;
    drain_mode = 1;
    do_reset();
    dat[2] = 8'h22;
    dat[3] = 8'h33;
    req = 4'b0100;
    cycle();
    check_eq("t4_lock2", locked, 1);
    req = 4'b1000;
    cycle();
    check_eq("t4_d", l_obs_d, 8'h33);
    check_eq("t4_owner", owner, 3);
    check_eq("t4_locked", locked, 1);

    // Reset while locked discards the lock.
    req = '0;
    do_reset();
    req = 4'b1111;
    cycle();
    reset = 1'b1;
    cycle();
    check_eq("t5_rst_ack", l_obs_ack, 0);
    check_eq("t5_owner", owner, 3);
    check_eq("t5_locked", locked, 0);
    reset = 1'b0;
    cycle();
    check_eq("t5_first", l_obs_ack, 4'b0001);

`ifdef FIFO_ARB_STATS_EN
    req = '0;
    do_reset();
    req = 4'b0010;
    for (int k = 0; k < 5; k++) cycle();
    req = '0;
    stat_sel = 2'd1;
    cycle();
    check_eq("t6_count5", stat_count, 5);
    stat_clear = 1'b1;
    cycle();
    stat_clear = 1'b0;
    cycle();
    check_eq("t6_clear", stat_count, 0);
    req = 4'b0010;
    for (int k = 0; k < 65540; k++) cycle();
    req = '0;
    cycle();
    check_eq("t6_sat", stat_count, 16'hFFFF);
`endif

    // Random traffic with a small, randomly drained fifo.
    req = '0;
    do_reset();
    fdepth = 3;
    drain_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      stat_sel = IW'($urandom_range(0, N - 1));
      stat_clear = ($urandom_range(0, 49) == 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        if (l_fire && l_cand == i) begin
          if ($urandom_range(0, 1) == 1) dat[i] = W'($urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          dat[i] = W'($urandom);
        end
      end
    end
    reset = 1'b0;
    stat_clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of one fifo (d_in / d_in_strobe, gated by full) between NREQ requester channels in the io881 datapath. Grants are round-robin, with an optional per-owner burst lock of up to BURST consecutive writes. Each requester sees a simple req/ack handshake; the fifo side sees a single writer that never strobes while full.

Parameters:
WIDTH, 8, data width; matches the fifo WIDTH.
NREQ, 4, number of requester channels (2..8).
BURST, 2, maximum consecutive writes one owner may make while holding req; 1 gives pure round-robin.
IDXW, 2, requester index width; must satisfy 2**IDXW >= NREQ.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
req  input  NREQ  per-requester write request; held high with data stable until acked.
req_data  input  NREQ*WIDTH  packed requester data; channel i occupies bits [i*WIDTH +: WIDTH].
ack  output  NREQ  one-hot, combinational; high in the cycle channel i's word is written.
fifo_d_in  output  WIDTH  data to the fifo d_in.
fifo_d_in_strobe  output  1  write strobe to the fifo d_in_strobe.
fifo_full  input  1  fifo full flag.
owner  output  IDXW  registered index of the last channel granted.
locked  output  1  registered; the owner holds a burst lock.

Behaviour:
- Reset: owner=NREQ-1 (so the first search starts at channel 0), burst_cnt=0, locked=0. While reset is high, ack=0 and fifo_d_in_strobe=0. Reset mid-transfer discards the lock; the requester keeps req high and is re-arbitrated after reset.
- Candidate selection (combinational):
  - If locked and req[owner], the candidate is owner.
  - Otherwise the candidate is the first i with req[i]=1, scanning owner+1, owner+2, ... modulo NREQ, ending with owner itself.
  - No req bits high means no candidate.
- Fire condition: a candidate exists and fifo_full=0 and reset=0.
- On fire:
  - fifo_d_in_strobe=1, fifo_d_in=req_data[candidate], ack[candidate]=1, all in the same cycle. Zero-latency handshake; the fifo captures on the next posedge.
  - With no fire, fifo_d_in_strobe=0, ack=0, and fifo_d_in drives req_data of the candidate (or 0 when there is no candidate).
- State update on a fire edge:
  - new_cnt = (locked && candidate==owner) ? burst_cnt+1 : 1.
  - owner<=candidate, burst_cnt<=new_cnt, locked<=(new_cnt < BURST).
- State update on an edge with no fire:
  - fifo_full=1 with a candidate present: state holds and the lock is retained.
  - Locked owner has dropped req: locked<=0 and burst_cnt<=0; owner is unchanged, so the next search starts at owner+1.
- Back-to-back writes are allowed every cycle; fifo_full is re-sampled each cycle. The arbiter never strobes while fifo_full=1.
- A requester whose req is low is never acked. A requester may raise req in the same cycle it is acked only if it presents new data.
- Fairness: with all channels requesting continuously, each channel gets exactly BURST consecutive writes before rotation.

Optional Feature:
FIFO_ARB_STATS_EN.
- Defined, adds ports:
  - stat_sel  input  IDXW
  - stat_clear  input  1
  - stat_count  output  16
- Each channel has a 16-bit write counter, incremented on every fire for that channel and saturating at 16'hFFFF.
- stat_count = counter[stat_sel], registered (1-cycle latency).
- stat_clear (synchronous) zeroes all counters. A fire in the same cycle as stat_clear is not counted.
- Reset zeroes all counters and stat_count.
- Undefined: the ports and counters are absent; arbitration is identical.

Decomposition:
- Shared package fifo_arb_pkg: IDXW derivation, the stat counter width (16), and the saturation constant.
- One natural sub-module: rr_pick (combinational rotating priority encoder: req vector and start index in, found flag and index out). It is reused by other io881 arbiters.

Test Plan:
1. Reset, then req=4'b0001, req_data[0]=8'h55, fifo empty -> same cycle ack=4'b0001, strobe=1, d_in=8'h55; after the edge owner=0, locked=1; fifo q=8'h55.
2. All four req high with data 8'h10..8'h13, fifo drained every cycle -> write order 10,10,11,11,12,12,13,13,10 (each word re-presented after ack); locked toggles 1,0 per pair.
3. Fifo DEPTH=2 not drained, req=4'b0011 -> two writes (8'hA0, 8'hA0 from channel 0 at BURST=2), then full=1 -> strobe=0 and ack=0 while full; after one q_out_strobe, channel 0 continues if its burst is unfinished, otherwise channel 1 (8'hA1).
4. Locked owner 2 drops req after one write while req[3]=1 -> next write is from channel 3, and locked=1 after it.
5. Assert reset while locked=1 with req=4'b1111 -> next cycle owner=3, locked=0; the first post-reset grant goes to channel 0.
6. With FIFO_ARB_STATS_EN: 5 writes from channel 1, stat_sel=1 -> stat_count=5 one cycle later; stat_clear -> 0; preload near 16'hFFFF -> count saturates at 16'hFFFF.
